// File: rtl/muldiv_wb_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per cycle,
// result held on a register-file writeback port until the consumer takes it.
//   state | meaning
//   IDLE  | waiting for an operation, in_ready high
//   RUN   | one iteration per cycle on operand magnitudes
//   DONE  | result presented on the writeback port until accepted or killed
module muldiv_wb_unit #(
    parameter int WIDTH = 32,
    parameter int ADDRW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic [ADDRW-1:0] rd,
    input  logic             kill,
    output logic             busy,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic             wb_we,
    output logic [ADDRW-1:0] wb_addr,
    output logic [WIDTH-1:0] wb_data
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [5:0]       LAST_ITER = 6'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [ADDRW-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;

    // Operand conditioning at accept time: the datapath only ever sees magnitudes.
    logic             a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             div_zero, div_ovf;
    logic [WIDTH-1:0] special_res;

    always_comb begin
        a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        a_neg    = a_signed & rs1_val[WIDTH-1];
        b_neg    = b_signed & rs2_val[WIDTH-1];
        a_mag    = a_neg ? -rs1_val : rs1_val;
        b_mag    = b_neg ? -rs2_val : rs2_val;
        div_zero = op[2] && (rs2_val == '0);
        div_ovf  = op[2] && !op[0] && (rs1_val == MOST_NEG) && (rs2_val == '1);
        if (div_zero) begin
            special_res = op[1] ? rs1_val : '1;
        end else begin
            special_res = op[1] ? '0 : rs1_val;
        end
    end

    // One iteration: hi/lo hold {product} for multiply and {remainder, quotient} for divide.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift[WIDTH-1:0] - opb_q;
        if (op_q[2]) begin
            step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        prod = negq_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        quo  = negq_q ? -step_lo : step_lo;
        rem  = negr_q ? -step_hi : step_hi;
        if (!op_q[2]) begin
            fin_res = (op_q == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        end else begin
            fin_res = op_q[1] ? rem : quo;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        res_d   = res_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    rd_d   = rd;
                    cnt_d  = '0;
                    hi_d   = '0;
                    lo_d   = a_mag;
                    opb_d  = b_mag;
                    negq_d = a_neg ^ b_neg;
                    negr_d = a_neg;
                    if (div_zero || div_ovf) begin
                        res_d   = special_res;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (kill) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == LAST_ITER) begin
                        res_d   = fin_res;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (kill || wb_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
        end
    end

    assign in_ready = (state_q == S_IDLE);
    assign busy     = (state_q == S_RUN) || (state_q == S_DONE);
    assign wb_valid = (state_q == S_DONE);
    assign wb_data  = wb_valid ? res_q : '0;
    assign wb_addr  = rd_q;
    assign wb_we    = wb_valid && wb_ready && (rd_q != '0);

endmodule

// File: tb/tb_muldiv_wb_unit.sv
// Self-checking bench for muldiv_wb_unit: directed vectors plus a cycle-level
// arithmetic model compared against the DUT on every falling edge.
module tb_muldiv_wb_unit;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b1;
    logic          in_valid = 1'b0;
    logic [2:0]    op       = 3'b000;
    logic [W-1:0]  rs1_val  = '0;
    logic [W-1:0]  rs2_val  = '0;
    logic [AW-1:0] rd       = '0;
    logic          kill     = 1'b0;
    logic          wb_ready = 1'b1;
    logic          in_ready, busy, wb_valid, wb_we;
    logic [AW-1:0] wb_addr;
    logic [W-1:0]  wb_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_wb_unit #(.WIDTH(W), .ADDRW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .op       (op),
        .rs1_val  (rs1_val),
        .rs2_val  (rs2_val),
        .rd       (rd),
        .kill     (kill),
        .busy     (busy),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_we    (wb_we),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of each operation, straight from the arithmetic definitions.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint      sa, sb, ub;
        logic [63:0] p;
        int          ai, bi;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        ai = a;
        bi = b;
        p  = '0;
        case (o)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin p = sa * sb;                 return p[63:32]; end
            3'b010: begin p = sa * ub;                 return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(ai / bi);
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ai % bi);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        return o[2] && ((b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Transaction-level model: idle / computing (edges left) / result pending.
    logic          m_busy  = 1'b0;
    logic          m_valid = 1'b0;
    int            m_left  = 0;
    logic [W-1:0]  m_data  = '0;
    logic [AW-1:0] m_addr  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            m_left  <= 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy  <= 1'b1;
                m_data  <= ref_result(op, rs1_val, rs2_val);
                m_addr  <= rd;
                m_valid <= is_special(op, rs1_val, rs2_val);
                m_left  <= W;
            end
        end else if (kill) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end else if (!m_valid) begin
            if (m_left == 1) m_valid <= 1'b1;
            m_left <= m_left - 1;
        end else if (wb_ready) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
        end
    end

    always @(negedge clk) begin
        check("cyc in_ready", in_ready, !m_busy);
        check("cyc busy", busy, m_busy);
        check("cyc wb_valid", wb_valid, m_valid);
        check("cyc wb_data", wb_data, m_valid ? m_data : '0);
        check("cyc wb_we", wb_we, m_valid && wb_ready && (m_addr != 0));
        if (m_valid) check("cyc wb_addr", wb_addr, m_addr);
    end

    task automatic check_reset_outputs();
        check("rst in_ready", in_ready, 1'b1);
        check("rst busy", busy, 1'b0);
        check("rst wb_valid", wb_valid, 1'b0);
        check("rst wb_we", wb_we, 1'b0);
        check("rst wb_addr", wb_addr, '0);
        check("rst wb_data", wb_data, '0);
    endtask

    task automatic drive_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] r, input logic rdy);
        op       = o;
        rs1_val  = a;
        rs2_val  = b;
        rd       = r;
        wb_ready = rdy;
        in_valid = 1'b1;
    endtask

    // Next posedge is the accept edge; latency counts falling edges until wb_valid is seen,
    // which equals the number of rising edges until the consumer can sample it high.
    task automatic finish_op(input logic [31:0] exp, input int exp_lat, input logic [4:0] r,
                             input logic rdy);
        int n;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        rs1_val  = $urandom;
        rs2_val  = $urandom;
        rd       = 5'(~r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wb_valid && n < 100);
        check("latency", 64'(n), 64'(exp_lat));
        check("wb_data", wb_data, exp);
        check("wb_addr", wb_addr, r);
        check("wb_we", wb_we, rdy && (r != 0));
        if (rdy) begin
            @(posedge clk);
            #2;
            check("in_ready after wb", in_ready, 1'b1);
            check("wb_valid after wb", wb_valid, 1'b0);
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] exp, input int exp_lat,
                          input logic rdy);
        @(posedge clk);
        #2;
        check("model pin", ref_result(o, a, b), exp);
        drive_op(o, a, b, r, rdy);
        finish_op(exp, exp_lat, r, rdy);
    endtask

    initial begin
        int seen;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // multiply variants
        run_op(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33, 1'b1);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  32'hFFFF_FFFE, 33, 1'b1);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 33, 1'b1);
        run_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 33, 1'b1);
        run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 33, 1'b1);
        run_op(3'b011, 32'h8000_0000, 32'd2,         5'd6,  32'h0000_0001, 33, 1'b1);
        run_op(3'b010, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd20, 32'h7FFF_FFFE, 33, 1'b1);
        // divide variants
        run_op(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD, 33, 1'b1);
        run_op(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF, 33, 1'b1);
        run_op(3'b101, 32'd100,       32'd7,         5'd9,  32'd14,        33, 1'b1);
        run_op(3'b111, 32'd100,       32'd7,         5'd10, 32'd2,         33, 1'b1);
        run_op(3'b100, 32'd7,         32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 33, 1'b1);
        run_op(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd12, 32'd1,         33, 1'b1);
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1,         5'd31, 32'hFFFF_FFFF, 33, 1'b1);
        // divide by zero and signed overflow shortcut
        run_op(3'b101, 32'h1234,      32'd0,         5'd13, 32'hFFFF_FFFF, 1,  1'b1);
        run_op(3'b111, 32'h1234,      32'd0,         5'd14, 32'h0000_1234, 1,  1'b1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1,  1'b1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1,  1'b1);
        run_op(3'b100, 32'd5,         32'd0,         5'd17, 32'hFFFF_FFFF, 1,  1'b1);
        // rd = 0 still produces a result but never writes
        run_op(3'b000, 32'h1234,      32'h10,        5'd0,  32'h0001_2340, 33, 1'b1);

        // writeback stall: result must hold and new requests must be ignored
        run_op(3'b101, 32'd100, 32'd7, 5'd9, 32'd14, 33, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 1) drive_op(3'b000, 32'd3, 32'd3, 5'd2, 1'b0);
            @(negedge clk);
            check("stall wb_valid", wb_valid, 1'b1);
            check("stall wb_data", wb_data, 32'd14);
            check("stall wb_addr", wb_addr, 5'd9);
            check("stall in_ready", in_ready, 1'b0);
        end
        @(posedge clk);
        #2 in_valid = 1'b0;
        wb_ready = 1'b1;
        @(posedge clk);
        #2 check("stall released", in_ready, 1'b1);

        // kill while idle does nothing; kill in DONE drops the result
        kill = 1'b1;
        repeat (3) @(posedge clk);
        #2 check("idle kill in_ready", in_ready, 1'b1);
        kill = 1'b0;
        run_op(3'b101, 32'd9, 32'd3, 5'd4, 32'd3, 33, 1'b0);
        #1 kill = 1'b1;
        @(posedge clk);
        #2 kill = 1'b0;
        check("done kill wb_valid", wb_valid, 1'b0);
        check("done kill in_ready", in_ready, 1'b1);
        wb_ready = 1'b1;

        // kill at iteration 10
        @(posedge clk);
        #2 drive_op(3'b000, 32'd123, 32'd456, 5'd3, 1'b1);
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 kill = 1'b1;
        @(posedge clk);
        #2 kill = 1'b0;
        check("run kill busy", busy, 1'b0);
        check("run kill in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (wb_valid) seen++;
        end
        check("run kill no wb", 64'(seen), 64'd0);

        // reset mid-RUN, then an op accepted on the first edge after release
        @(posedge clk);
        #2 drive_op(3'b100, 32'd1000, 32'd7, 5'd6, 1'b1);
        @(posedge clk);
        #2 in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_reset_outputs();
        @(posedge clk);
        #1 check_reset_outputs();
        #2 rst_n = 1'b1;
        drive_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 1'b1);
        finish_op(32'hFFFF_FFEB, 33, 5'd5, 1'b1);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
